frv_core_fetch_issue: RTL and testbench

FRV_CORE_FETCH_ISSUE -- requirements
Module: frv_core_fetch_issue

---
 rtl/frv_core_fetch_issue_pkg.sv | 17 +
 rtl/frv_core_fetch_issue_if.sv | 23 ++
 rtl/frv_core_fetch_issue.sv | 116 +++++++++++
 tb/tb_frv_core_fetch_issue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_core_fetch_issue_pkg.sv
// Shared widths, FSM encoding and address helper for the instruction fetch/issue block.
package frv_core_fetch_issue_pkg;

    localparam int XL     = 32;
    localparam int OUTS_W = 2;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [XL-1:0] word_align(input logic [XL-1:0] a);
        return a & ~XL'(3);
    endfunction

endpackage

// File: rtl/frv_core_fetch_issue_if.sv
// Instruction memory bus: a request channel (req/gnt/addr) and a response channel (recv/ack/data).
interface frv_core_fetch_issue_if;
    import frv_core_fetch_issue_pkg::*;

    logic          imem_req;
    logic          imem_gnt;
    logic [XL-1:0] imem_addr;
    logic          imem_recv;
    logic          imem_ack;
    logic          imem_error;
    logic [XL-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr, imem_ack,
        input  imem_gnt, imem_recv, imem_error, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, imem_ack,
        output imem_gnt, imem_recv, imem_error, imem_rdata
    );

endinterface

// File: rtl/frv_core_fetch_issue.sv
// Fetch front end: issues word fetches, forwards responses to the fetch buffer and
// handles control-flow redirects by draining responses still in flight.
module frv_core_fetch_issue
    import frv_core_fetch_issue_pkg::*;
#(
    parameter logic [XL-1:0] FRV_PC_RESET = 32'h8000_0000,
    parameter int            MAX_OUTS     = 2
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    input  logic                  cf_req,
    input  logic [XL-1:0]         cf_target,
    output logic                  cf_ack,
    frv_core_fetch_issue_if.master imem,
    output logic                  f_4byte,
    output logic                  f_2byte,
    output logic                  f_err,
    output logic [XL-1:0]         f_in,
    input  logic                  f_ready,
    output logic                  flush,
    output fetch_state_t          dbg_state
);

    // Handshakes: a request moves when imem_req && imem_gnt, a response when
    // imem_recv && imem_ack, a redirect when cf_req && cf_ack; once raised, imem_req
    // and imem_addr hold until granted because redirects wait out a pending request.

    localparam logic [OUTS_W-1:0] MAX_OUTS_C = OUTS_W'(MAX_OUTS);
    localparam logic [OUTS_W-1:0] ONE        = OUTS_W'(1);

    fetch_state_t      state, state_nx;
    logic [XL-1:0]     fetch_addr;
    logic              half_pending;
    logic [OUTS_W-1:0] outs, outs_nx;
    logic [OUTS_W-1:0] discard, discard_nx;
    logic              run_st, drain_st;
    logic              gnt_xfer, resp_xfer, deliver;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_nx;
        end
    end

    // discard counts responses that belong to the abandoned stream; it is loaded from
    // outs after this cycle's grant and response have been accounted for.
    always_comb begin
        outs_nx = outs;
        if (gnt_xfer && !resp_xfer) begin
            outs_nx = outs + ONE;
        end else if (!gnt_xfer && resp_xfer) begin
            outs_nx = outs - ONE;
        end

        discard_nx = discard;
        if (state == ST_DRAIN && resp_xfer) begin
            discard_nx = discard - ONE;
        end
        if (state == ST_RUN && cf_ack) begin
            discard_nx = outs_nx;
        end

        state_nx = state;
        case (state)
            ST_RESET: state_nx = ST_RUN;
            ST_RUN:   if (cf_ack && discard_nx != '0) state_nx = ST_DRAIN;
            ST_DRAIN: if (discard_nx == '0) state_nx = ST_RUN;
            default:  state_nx = ST_RESET;
        endcase
    end

    always_comb begin
        run_st         = !g_reset && (state == ST_RUN);
        drain_st       = !g_reset && (state == ST_DRAIN);
        imem.imem_addr = fetch_addr;
        imem.imem_req  = run_st && (outs < MAX_OUTS_C);
        imem.imem_ack  = run_st ? f_ready : drain_st;
        cf_ack         = cf_req && (run_st || drain_st) && !(imem.imem_req && !imem.imem_gnt);
        flush          = g_reset || (state == ST_RESET) || cf_ack;
        gnt_xfer       = imem.imem_req && imem.imem_gnt;
        resp_xfer      = imem.imem_recv && imem.imem_ack;
        deliver        = run_st && resp_xfer && !cf_ack;
        f_2byte        = deliver && half_pending;
        f_4byte        = deliver && !half_pending;
        f_err          = deliver && imem.imem_error;
        f_in           = imem.imem_rdata;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            fetch_addr   <= word_align(FRV_PC_RESET);
            half_pending <= FRV_PC_RESET[1];
            outs         <= '0;
            discard      <= '0;
        end else begin
            outs    <= outs_nx;
            discard <= discard_nx;
            if (cf_ack) begin
                fetch_addr   <= word_align(cf_target);
                half_pending <= cf_target[1];
            end else begin
                if (gnt_xfer) begin
                    fetch_addr <= fetch_addr + XL'(4);
                end
                if (deliver) begin
                    half_pending <= 1'b0;
                end
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_frv_core_fetch_issue.sv
// Bench for the fetch/issue block: random memory slave, stream-level reference model
// (epochs of sequential addresses per redirect) and a scoreboard on the fetch-buffer side.
module tb_frv_core_fetch_issue;
    import frv_core_fetch_issue_pkg::*;

    localparam logic [31:0] PC_RESET = 32'h8000_0000;
    localparam int          MAX_OUTS = 2;
    localparam int          W        = 35;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } pend_t;

    logic         g_clk     = 1'b0;
    logic         g_reset   = 1'b1;
    logic         cf_req    = 1'b0;
    logic [31:0]  cf_target = 32'h0;
    logic         f_ready   = 1'b1;
    logic         cf_ack, f_4byte, f_2byte, f_err, flush;
    logic [31:0]  f_in;
    fetch_state_t dbg_state;

    frv_core_fetch_issue_if imem ();

    frv_core_fetch_issue #(
        .FRV_PC_RESET(PC_RESET),
        .MAX_OUTS    (MAX_OUTS)
    ) dut (
        .g_clk    (g_clk),
        .g_reset  (g_reset),
        .cf_req   (cf_req),
        .cf_target(cf_target),
        .cf_ack   (cf_ack),
        .imem     (imem),
        .f_4byte  (f_4byte),
        .f_2byte  (f_2byte),
        .f_err    (f_err),
        .f_in     (f_in),
        .f_ready  (f_ready),
        .flush    (flush),
        .dbg_state(dbg_state)
    );

    always #5 g_clk = ~g_clk;

    pend_t          pend_q[$];
    logic [W-1:0]   exp_q[$];
    int             n_checks  = 0;
    int             n_errors  = 0;
    int             gnt_pct   = 100;
    int             recv_pct  = 100;
    int             ready_pct = 100;
    int             cf_pct    = 0;
    int             epoch     = 0;
    int             n_deliv   = 0;
    int             n_half    = 0;
    int             n_drop    = 0;
    logic [31:0]    model_pc;
    logic           model_half;
    logic           rst_q;
    logic [31:0]    pc_rst_v  = PC_RESET;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return &a[7:2];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge g_clk) rst_q <= g_reset;

    // Reference model: each accepted redirect opens a new epoch; only responses from
    // the current epoch reach the fetch buffer, in address order from the target.
    initial begin : model
        logic  rst_phase, stale, exp_req, exp_ack, exp_cfa, gnt_x, resp_x;
        pend_t e;
        forever begin
            @(negedge g_clk);
            rst_phase = g_reset || rst_q;
            if (g_reset) begin
                pend_q.delete();
                model_pc   = pc_rst_v & ~32'h3;
                model_half = pc_rst_v[1];
            end
            stale   = (pend_q.size() > 0) && (pend_q[0].epoch != epoch);
            exp_req = !rst_phase && !stale && (pend_q.size() < MAX_OUTS);
            exp_ack = rst_phase ? 1'b0 : (stale ? 1'b1 : f_ready);
            exp_cfa = cf_req && !rst_phase && !(exp_req && !imem.imem_gnt);

            check("imem_req", W'(imem.imem_req), W'(exp_req));
            check("imem_ack", W'(imem.imem_ack), W'(exp_ack));
            check("cf_ack", W'(cf_ack), W'(exp_cfa));
            check("flush", W'(flush), W'(rst_phase || exp_cfa));
            if (exp_req) check("imem_addr", W'(imem.imem_addr), W'(model_pc));
            if (rst_q && !g_reset) check("state_boot", W'(dbg_state == ST_RESET), W'(1'b1));
            if (!rst_phase) check("state_drain", W'(dbg_state == ST_DRAIN), W'(stale));

            gnt_x  = exp_req && imem.imem_gnt;
            resp_x = imem.imem_recv && exp_ack;
            if (resp_x && pend_q.size() > 0) begin
                e = pend_q.pop_front();
                if (e.epoch == epoch && !exp_cfa) begin
                    exp_q.push_back({model_half, !model_half, mem_err(e.addr), mem_data(e.addr)});
                    model_half = 1'b0;
                end else begin
                    n_drop++;
                end
            end
            if (gnt_x) begin
                e.addr  = model_pc;
                e.epoch = epoch;
                pend_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
            if (exp_cfa) begin
                epoch++;
                model_pc   = cf_target & ~32'h3;
                model_half = cf_target[1];
            end
        end
    end

    initial begin : monitor
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        forever begin
            @(negedge g_clk);
            #1;
            act_v = {f_2byte, f_4byte, f_err, f_in};
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                check("f_word", act_v, exp_v);
                n_deliv++;
                if (exp_v[W-1]) n_half++;
            end else begin
                check("f_strobe_idle", W'({f_2byte, f_4byte}), W'(2'b00));
            end
            if (!f_4byte && !f_2byte) check("f_err_idle", W'(f_err), W'(1'b0));
            check("f_onehot", W'(f_4byte && f_2byte), W'(1'b0));
        end
    end

    // Memory slave: in-order responses for granted addresses, garbage when idle.
    initial begin : slave
        imem.imem_gnt   = 1'b0;
        imem.imem_recv  = 1'b0;
        imem.imem_error = 1'b0;
        imem.imem_rdata = 32'h0;
        forever begin
            @(posedge g_clk);
            #1;
            imem.imem_gnt = (int'($urandom_range(1, 100)) <= gnt_pct);
            if (pend_q.size() > 0 && int'($urandom_range(1, 100)) <= recv_pct) begin
                imem.imem_recv  = 1'b1;
                imem.imem_rdata = mem_data(pend_q[0].addr);
                imem.imem_error = mem_err(pend_q[0].addr);
            end else begin
                imem.imem_recv  = 1'b0;
                imem.imem_rdata = $urandom;
                imem.imem_error = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic step();
        @(posedge g_clk);
        #1;
        f_ready   = (int'($urandom_range(1, 100)) <= ready_pct);
        cf_req    = (int'($urandom_range(1, 100)) <= cf_pct);
        cf_target = $urandom;
    endtask

    task automatic redirect(input logic [31:0] t);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        cf_req    = 1'b1;
        cf_target = t;
        while (!acc && n < 50) begin
            @(negedge g_clk);
            acc = cf_ack;
            n++;
            @(posedge g_clk);
            #1;
            f_ready = (int'($urandom_range(1, 100)) <= ready_pct);
        end
        cf_req = 1'b0;
        n_checks++;
        if (!acc) begin
            n_errors++;
            $display("FAIL redirect_timeout: target 0x%08h not accepted after %0d cycles", t, n);
        end
    endtask

    task automatic set_knobs(input int g, input int r, input int f, input int c);
        gnt_pct   = g;
        recv_pct  = r;
        ready_pct = f;
        cf_pct    = c;
    endtask

    initial begin : main
        // Boot: grant always, response one cycle after grant.
        set_knobs(100, 100, 100, 0);
        repeat (3) step();
        g_reset = 1'b0;
        repeat (20) step();

        // Halfword redirect target.
        redirect(32'h0000_1006);
        repeat (10) step();

        // Drain two stale responses after a redirect.
        set_knobs(100, 0, 100, 0);
        repeat (4) step();
        redirect(32'h0000_0200);
        recv_pct = 100;
        repeat (10) step();

        // Fetch buffer backpressure with responses waiting.
        set_knobs(100, 0, 100, 0);
        repeat (4) step();
        set_knobs(100, 100, 0, 0);
        repeat (6) step();
        ready_pct = 100;
        repeat (8) step();

        // Grant stall while a redirect is requested.
        set_knobs(0, 100, 100, 0);
        repeat (4) step();
        fork
            redirect(32'h0000_3000);
            begin
                repeat (3) @(posedge g_clk);
                gnt_pct = 100;
            end
        join
        repeat (10) step();

        // Error response at the top of the address space, then wrap.
        redirect(32'hFFFF_FFFC);
        repeat (10) step();

        // Random traffic with a reset in the middle.
        set_knobs(70, 60, 70, 4);
        repeat (3000) step();
        g_reset = 1'b1;
        repeat (2) step();
        g_reset = 1'b0;
        repeat (1500) step();

        set_knobs(100, 100, 100, 0);
        repeat (20) step();

        check("deliveries_seen", W'(n_deliv > 100), W'(1'b1));
        check("half_seen", W'(n_half > 0), W'(1'b1));
        check("drops_seen", W'(n_drop > 0), W'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
